clsim_gen: RTL and testbench



---
 rtl/clsim_gen_if.sv | 17 +
 rtl/clsim_gen.sv | 198 +++++++++++++++++++
 tb/tb_clsim_gen.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clsim_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : clsim_gen_if
// Purpose  : Camera Link framing and pixel bus between camera and grabber.
// Revision : 1.0 - initial release
// ============================================================================
interface clsim_gen_if #(
  parameter int N_TAP = 10
) ();
  logic               cl_fval;
  logic               cl_z_lval;
  logic [8*N_TAP-1:0] cl_port;

  modport master (output cl_fval, output cl_z_lval, output cl_port);
  modport slave  (input  cl_fval, input  cl_z_lval, input  cl_port);
endinterface
`default_nettype wire

// File: rtl/clsim_gen.sv
`default_nettype none
// ============================================================================
// Module   : clsim_gen
// Purpose  : Camera Link camera simulator: FVAL/LVAL framing, test patterns,
//            run/stop control and frame-count-limited bursts.
// Revision : 1.0 - initial release
// ============================================================================
module clsim_gen #(
  parameter int N_TAP    = 10,
  parameter int N_COL    = 780,
  parameter int N_ROW    = 1080,
  parameter int FVAL_LOW = 40,
  parameter int LVAL_LOW = 7,
  parameter int FCNT_W   = 20
) (
  input  wire                 reset,
  input  wire                 cl_z_pclk,
  input  wire                 run,
  input  wire  [1:0]          pattern,
  input  wire  [15:0]         n_frames,
  clsim_gen_if.master         cl,
  output logic [FCNT_W-1:0]   frame_count,
  output logic                done
);

  localparam int CW   = (N_COL > 1) ? $clog2(N_COL) : 1;
  localparam int RW   = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam int GMAX = (FVAL_LOW > LVAL_LOW) ? FVAL_LOW : LVAL_LOW;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

  localparam logic [CW-1:0] c_COL_LAST  = CW'(N_COL - 1);
  localparam logic [RW-1:0] c_ROW_LAST  = RW'(N_ROW - 1);
  localparam logic [GW-1:0] c_FGAP_LAST = GW'(FVAL_LOW - 1);
  localparam logic [GW-1:0] c_LGAP_LAST = GW'(LVAL_LOW - 1);

  localparam logic [1:0] c_PAT_TOGGLE = 2'd0;
  localparam logic [1:0] c_PAT_RAMP   = 2'd1;
  localparam logic [1:0] c_PAT_STAMP  = 2'd2;
  localparam logic [1:0] c_PAT_CONST  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FGAP = 3'd1,
    S_LINE = 3'd2,
    S_LGAP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             r_state;
  logic [GW-1:0]      r_gap;
  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [15:0]        r_burst;
  logic [1:0]         r_pat;
  logic               r_tgl;
  logic               r_fval;
  logic               r_lval;
  logic               r_done;
  logic [FCNT_W-1:0]  r_fcnt;
  logic [8*N_TAP-1:0] r_port;

  logic [CW-1:0]      w_col_inc;
  logic [RW-1:0]      w_row_inc;
  logic [15:0]        w_burst_inc;
  logic [FCNT_W-1:0]  w_fcnt_inc;

  assign w_col_inc   = r_col + 1'b1;
  assign w_row_inc   = r_row + 1'b1;
  assign w_burst_inc = r_burst + 1'b1;
  assign w_fcnt_inc  = r_fcnt + 1'b1;

  // Pixel word for the cycle being registered; arguments are next-cycle values.
  function automatic logic [8*N_TAP-1:0] f_pixels(
    input logic [1:0]        pat,
    input logic              lval,
    input logic [CW-1:0]     col,
    input logic [RW-1:0]     row,
    input logic [FCNT_W-1:0] fc,
    input logic              tgl
  );
    logic [8*N_TAP-1:0] px;
    logic [7:0]         seed;
    px = '0;
    for (int k = 0; k < N_TAP; k++) begin
      seed = 8'(8'h0A + k);
      if (pat == c_PAT_TOGGLE) begin
        px[8*k +: 8] = seed ^ {3'b000, tgl, 4'b0000};
      end else if (lval) begin
        case (pat)
          c_PAT_RAMP:  px[8*k +: 8] = 8'(32'(col) * N_TAP + k);
          c_PAT_STAMP: begin
            if (k == 0)      px[8*k +: 8] = 8'(row);
            else if (k == 1) px[8*k +: 8] = 8'(fc);
            else             px[8*k +: 8] = 8'(32'(col) + k);
          end
          default:     px[8*k +: 8] = 8'(8'hA5 ^ k);
        endcase
      end
    end
    return px;
  endfunction

  always_ff @(posedge cl_z_pclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_burst <= '0;
      r_pat   <= c_PAT_TOGGLE;
      r_tgl   <= 1'b0;
      r_fval  <= 1'b0;
      r_lval  <= 1'b0;
      r_done  <= 1'b0;
      r_fcnt  <= '0;
      r_port  <= f_pixels(c_PAT_TOGGLE, 1'b0, '0, '0, '0, 1'b0);
    end else begin
      r_tgl  <= ~r_tgl;
      r_port <= f_pixels(r_pat, 1'b0, r_col, r_row, r_fcnt, ~r_tgl);
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FGAP;
            r_gap   <= '0;
            r_burst <= '0;
          end
        end
        S_FGAP: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else if (r_gap == c_FGAP_LAST) begin
            r_state <= S_LINE;
            r_fval  <= 1'b1;
            r_lval  <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
            r_fcnt  <= w_fcnt_inc;
            r_pat   <= pattern;
            r_port  <= f_pixels(pattern, 1'b1, '0, '0, w_fcnt_inc, ~r_tgl);
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_LINE: begin
          if (r_col == c_COL_LAST) begin
            r_lval <= 1'b0;
            if (r_row != c_ROW_LAST) begin
              r_state <= S_LGAP;
              r_gap   <= '0;
            end else begin
              // Frame complete: the burst limit outranks run.
              r_fval  <= 1'b0;
              r_burst <= w_burst_inc;
              if ((n_frames != '0) && (w_burst_inc == n_frames)) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else if (run) begin
                r_state <= S_FGAP;
                r_gap   <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end else begin
            r_col  <= w_col_inc;
            r_port <= f_pixels(r_pat, 1'b1, w_col_inc, r_row, r_fcnt, ~r_tgl);
          end
        end
        S_LGAP: begin
          if (r_gap == c_LGAP_LAST) begin
            r_state <= S_LINE;
            r_row   <= w_row_inc;
            r_col   <= '0;
            r_lval  <= 1'b1;
            r_port  <= f_pixels(r_pat, 1'b1, '0, w_row_inc, r_fcnt, ~r_tgl);
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_DONE: begin
          if (!run) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cl.cl_fval   = r_fval;
  assign cl.cl_z_lval = r_lval;
  assign cl.cl_port   = r_port;
  assign frame_count  = r_fcnt;
  assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_clsim_gen.sv
`default_nettype none
// Bench for clsim_gen: frame-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized control.
module tb_clsim_gen;

  localparam int N_TAP     = 2;
  localparam int N_COL     = 4;
  localparam int N_ROW     = 3;
  localparam int FVAL_LOW  = 5;
  localparam int LVAL_LOW  = 2;
  localparam int FCNT_W    = 3;
  localparam int P         = N_COL + LVAL_LOW;
  localparam int FRAME_LEN = N_ROW * N_COL + (N_ROW - 1) * LVAL_LOW;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_FRAME = 2;
  localparam int M_DONE  = 3;

  logic              cl_z_pclk = 1'b0;
  logic              reset     = 1'b1;
  logic              run       = 1'b0;
  logic [1:0]        pattern   = 2'd0;
  logic [15:0]       n_frames  = 16'd0;
  logic [FCNT_W-1:0] frame_count;
  logic              done;

  int checks   = 0;
  int failures = 0;

  clsim_gen_if #(.N_TAP(N_TAP)) cif ();

  clsim_gen #(
    .N_TAP(N_TAP), .N_COL(N_COL), .N_ROW(N_ROW),
    .FVAL_LOW(FVAL_LOW), .LVAL_LOW(LVAL_LOW), .FCNT_W(FCNT_W)
  ) dut (
    .reset(reset), .cl_z_pclk(cl_z_pclk), .run(run), .pattern(pattern),
    .n_frames(n_frames), .cl(cif), .frame_count(frame_count), .done(done)
  );

  always #5 cl_z_pclk = ~cl_z_pclk;

  // Reference model: mode plus time elapsed within the current frame.
  int         m_mode, m_wait, m_t, m_burst, m_fc;
  logic [1:0] m_pat;
  bit         m_tgl;

  task automatic mreset();
    m_mode = M_IDLE; m_wait = 0; m_t = 0; m_burst = 0; m_fc = 0;
    m_pat = 2'd0; m_tgl = 1'b0;
  endtask

  task automatic mstep();
    m_tgl = ~m_tgl;
    case (m_mode)
      M_IDLE: if (run) begin m_mode = M_WAIT; m_wait = 0; m_burst = 0; end
      M_WAIT: begin
        if (!run) m_mode = M_IDLE;
        else begin
          m_wait++;
          if (m_wait == FVAL_LOW) begin
            m_mode = M_FRAME; m_t = 0;
            m_fc = (m_fc + 1) % (1 << FCNT_W);
            m_pat = pattern;
          end
        end
      end
      M_FRAME: begin
        m_t++;
        if (m_t == FRAME_LEN) begin
          m_burst++;
          if (n_frames != 0 && m_burst == int'(n_frames)) m_mode = M_DONE;
          else if (run) begin m_mode = M_WAIT; m_wait = 0; end
          else m_mode = M_IDLE;
        end
      end
      default: if (!run) m_mode = M_IDLE;
    endcase
  endtask

  function automatic bit exp_lval();
    return (m_mode == M_FRAME) && ((m_t % P) < N_COL);
  endfunction

  function automatic logic [8*N_TAP-1:0] exp_port();
    logic [8*N_TAP-1:0] v;
    int row, col, b;
    v = '0;
    row = m_t / P;
    col = m_t % P;
    for (int k = 0; k < N_TAP; k++) begin
      b = 0;
      if (m_pat == 2'd0) b = (10 + k) ^ (m_tgl ? 16 : 0);
      else if (exp_lval()) begin
        case (m_pat)
          2'd1:    b = (col * N_TAP + k) % 256;
          2'd2:    b = (k == 0) ? row % 256 : (k == 1) ? m_fc % 256 : (col + k) % 256;
          default: b = 165 ^ k;
        endcase
      end
      v[8*k +: 8] = 8'(b);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge cl_z_pclk or posedge reset);
      if (reset) mreset();
      else mstep();
    end
  end

  initial begin
    forever begin
      @(negedge cl_z_pclk);
      chk("cyc_fval", cif.cl_fval, (m_mode == M_FRAME));
      chk("cyc_lval", cif.cl_z_lval, exp_lval());
      chk("cyc_port", cif.cl_port, exp_port());
      chk("cyc_fcnt", frame_count, m_fc);
      chk("cyc_done", done, (m_mode == M_DONE));
    end
  end

  // Waits (bounded) until fval reaches lvl; n = negedges waited.
  task automatic wait_fval(input logic lvl, input string name, output int n);
    n = 0;
    while (cif.cl_fval !== lvl && n < 300) begin
      @(negedge cl_z_pclk);
      n++;
    end
    if (cif.cl_fval !== lvl) chk(name, cif.cl_fval, lvl);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fval"}, cif.cl_fval, 0);
    chk({tag, "_lval"}, cif.cl_z_lval, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_port"}, cif.cl_port, 16'h0B0A);
    chk({tag, "_fcnt"}, frame_count, 0);
  endtask

  initial begin
    int n, rises;
    logic [15:0] a, b;

    repeat (3) @(negedge cl_z_pclk);
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (2) @(negedge cl_z_pclk);

    // Single RAMP frame burst
    pattern = 2'd1; n_frames = 16'd1; run = 1'b1;
    wait_fval(1'b1, "t1_rise_to", n);
    chk("t1_rise_lat", n, 6);
    chk("t1_px_c0", cif.cl_port, 16'h0100);
    @(negedge cl_z_pclk);
    chk("t1_px_c1", cif.cl_port, 16'h0302);
    wait_fval(1'b0, "t1_fall_to", n);
    chk("t1_fval_high", 1 + n, 16);
    chk("t1_done", done, 1);
    chk("t1_fcnt", frame_count, 1);
    run = 1'b0;
    @(negedge cl_z_pclk);
    chk("t1_done_clr", done, 0);

    // Continuous TOGGLE frames, frame_count wraps
    pattern = 2'd0; n_frames = 16'd0; run = 1'b1;
    wait_fval(1'b1, "t2_rise_to", n);
    a = cif.cl_port;
    @(negedge cl_z_pclk);
    b = cif.cl_port;
    chk("t2_tog_flip", a ^ b, 16'h1010);
    chk("t2_tog_val", (a == 16'h0B0A || a == 16'h1B1A), 1);
    chk("t2_fcnt0", frame_count, 2);
    for (int i = 1; i <= 8; i++) begin
      wait_fval(1'b0, "t2_fall_to", n);
      wait_fval(1'b1, "t2_rise_to", n);
      chk("t2_fgap_low", n, 5);
      chk("t2_fcnt", frame_count, (2 + i) % 8);
    end

    // run dropped mid-frame at row 1 col 2
    repeat (8) @(negedge cl_z_pclk);
    run = 1'b0;
    wait_fval(1'b0, "t3_fall_to", n);
    chk("t3_fval_high", 8 + n, 16);
    rises = 0;
    repeat (100) begin
      @(negedge cl_z_pclk);
      if (cif.cl_fval) rises++;
    end
    chk("t3_no_restart", rises, 0);

    // Pattern change mid-frame takes effect on the next frame
    pattern = 2'd1; run = 1'b1;
    wait_fval(1'b1, "t4_rise_to", n);
    repeat (3) @(negedge cl_z_pclk);
    pattern = 2'd3;
    wait_fval(1'b0, "t4_fall_to", n);
    wait_fval(1'b1, "t4_rise2_to", n);
    chk("t4_const_px", cif.cl_port, 16'hA4A5);
    run = 1'b0;
    wait_fval(1'b0, "t4_fall2_to", n);

    // Asynchronous reset mid-line
    run = 1'b1;
    wait_fval(1'b1, "t6_rise_to", n);
    @(negedge cl_z_pclk);
    #2 reset = 1'b1;
    #1 check_reset_vals("t6");
    @(negedge cl_z_pclk);
    reset = 1'b0;
    wait_fval(1'b1, "t6_rise2_to", n);
    chk("t6_rise_lat", n, 6);
    run = 1'b0;
    wait_fval(1'b0, "t6_fall_to", n);

    // STAMP burst of three frames from a fresh reset
    @(negedge cl_z_pclk);
    #2 reset = 1'b1;
    repeat (2) @(negedge cl_z_pclk);
    reset = 1'b0;
    pattern = 2'd2; n_frames = 16'd3; run = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_fval(1'b1, "t5_rise_to", n);
      chk("t5_row0", cif.cl_port, {8'(f + 1), 8'h00});
      repeat (P) @(negedge cl_z_pclk);
      chk("t5_row1", cif.cl_port, {8'(f + 1), 8'h01});
      repeat (P) @(negedge cl_z_pclk);
      chk("t5_row2", cif.cl_port, {8'(f + 1), 8'h02});
      wait_fval(1'b0, "t5_fall_to", n);
      if (f < 2) chk("t5_not_done", done, 0);
    end
    chk("t5_done", done, 1);
    chk("t5_fcnt", frame_count, 3);
    repeat (20) @(negedge cl_z_pclk);
    chk("t5_done_hold", done, 1);
    chk("t5_fval_hold", cif.cl_fval, 0);
    run = 1'b0;
    @(negedge cl_z_pclk);
    chk("t5_done_clr", done, 0);

    // Randomized control; the per-cycle model carries the checking
    repeat (1500) begin
      @(negedge cl_z_pclk);
      pattern  = 2'($urandom_range(0, 3));
      n_frames = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) run = ~run;
    end

    @(negedge cl_z_pclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
